cpu_exec_unit: RTL and testbench



---
 rtl/cpu_exec_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_cpu_exec_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_unit.sv
// Execution unit of the 16-bit CPU: multi-cycle ALU, program counter and stack pointer.
// Define CPU_EXEC_DIVIDER_EN to build the DIV/MOD restoring divider.
module cpu_exec_unit #(
  parameter logic [15:0] SP_TOP   = 16'h01FF,
  parameter logic [15:0] SP_FLOOR = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mov_enable,
  input  logic [5:0]  op_code,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        overflow_flag,
  output logic        carry_flag,
  output logic        negative_flag,
  output logic        zero_flag,
  input  logic        push,
  input  logic        pop,
  output logic [15:0] sp_out,
  input  logic        save_address_from_instr_mem,
  input  logic        save_address_from_data_mem,
  input  logic        save_address_from_counter,
  input  logic        increm_pc,
  input  logic [15:0] address_from_instr_mem,
  input  logic [15:0] address_from_data_mem,
  input  logic [15:0] address_from_counter_pc,
  output logic [15:0] pc_out,
  output logic [15:0] pc_out_for_mem
);

  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_MUL = 6'h03;
  localparam logic [5:0] OP_DIV = 6'h04;
  localparam logic [5:0] OP_MOD = 6'h05;
  localparam logic [5:0] OP_AND = 6'h06;
  localparam logic [5:0] OP_OR  = 6'h07;
  localparam logic [5:0] OP_XOR = 6'h08;
  localparam logic [5:0] OP_NOT = 6'h09;
  localparam logic [5:0] OP_LSL = 6'h0A;
  localparam logic [5:0] OP_LSR = 6'h0B;
  localparam logic [5:0] OP_INC = 6'h0C;
  localparam logic [5:0] OP_DEC = 6'h0D;
  localparam logic [5:0] OP_CMP = 6'h0E;
  localparam logic [5:0] OP_TST = 6'h0F;
  localparam logic [5:0] OP_MOV = 6'h10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state;
  logic [CNT_W-1:0] iter_cnt;
  logic [W-1:0]     acc_hi;   // mul: product high half; div: partial remainder
  logic [W-1:0]     acc_lo;   // mul: multiplier / product low half; div: dividend / quotient
  logic [W-1:0]     opnd;     // multiplicand or divisor

  // Single-cycle datapath
  logic [W:0]   add_ext, sub_ext, inc_ext, dec_ext, lsl_ext, lsr_ext;
  logic         add_v, sub_v, inc_v, dec_v;
  logic         sc_valid, sc_wr_res, sc_rem_clr, sc_v, sc_c;
  logic [W-1:0] sc_val;
  logic         start_mul, start_div;

  assign add_ext = {1'b0, b} + {1'b0, a};
  assign sub_ext = {1'b0, b} - {1'b0, a};
  assign inc_ext = {1'b0, b} + (W+1)'(1);
  assign dec_ext = {1'b0, b} - (W+1)'(1);
  assign lsl_ext = {1'b0, b} << a[3:0];
  assign lsr_ext = {b, 1'b0} >> a[3:0];
  assign add_v   = (b[W-1] == a[W-1]) && (add_ext[W-1] != b[W-1]);
  assign sub_v   = (b[W-1] != a[W-1]) && (sub_ext[W-1] != b[W-1]);
  assign inc_v   = !b[W-1] && inc_ext[W-1];
  assign dec_v   = b[W-1] && !dec_ext[W-1];

  always_comb begin
    sc_valid   = 1'b0;
    sc_wr_res  = 1'b1;
    sc_rem_clr = 1'b0;
    sc_val     = '0;
    sc_v       = 1'b0;
    sc_c       = 1'b0;
    start_mul  = 1'b0;
    start_div  = 1'b0;
    case (op_code)
      OP_ADD: begin sc_valid = 1'b1; sc_val = add_ext[W-1:0]; sc_c = add_ext[W]; sc_v = add_v; end
      OP_SUB: begin sc_valid = 1'b1; sc_val = sub_ext[W-1:0]; sc_c = sub_ext[W]; sc_v = sub_v; end
      OP_CMP: begin
        sc_valid = 1'b1; sc_wr_res = 1'b0;
        sc_val = sub_ext[W-1:0]; sc_c = sub_ext[W]; sc_v = sub_v;
      end
      OP_MUL: start_mul = 1'b1;
`ifdef CPU_EXEC_DIVIDER_EN
      OP_DIV, OP_MOD: start_div = 1'b1;
`else
      OP_DIV, OP_MOD: begin sc_valid = 1'b1; sc_rem_clr = 1'b1; sc_v = 1'b1; end
`endif
      OP_AND: begin sc_valid = 1'b1; sc_val = b & a; end
      OP_TST: begin sc_valid = 1'b1; sc_wr_res = 1'b0; sc_val = b & a; end
      OP_OR:  begin sc_valid = 1'b1; sc_val = b | a; end
      OP_XOR: begin sc_valid = 1'b1; sc_val = b ^ a; end
      OP_NOT: begin sc_valid = 1'b1; sc_val = ~b; end
      OP_LSL: begin sc_valid = 1'b1; sc_val = lsl_ext[W-1:0]; sc_c = lsl_ext[W]; end
      OP_LSR: begin sc_valid = 1'b1; sc_val = lsr_ext[W:1]; sc_c = lsr_ext[0]; end
      OP_INC: begin sc_valid = 1'b1; sc_val = inc_ext[W-1:0]; sc_c = inc_ext[W]; sc_v = inc_v; end
      OP_DEC: begin sc_valid = 1'b1; sc_val = dec_ext[W-1:0]; sc_c = dec_ext[W]; sc_v = dec_v; end
      OP_MOV: begin sc_valid = mov_enable; sc_val = a; end
      default: ;
    endcase
  end

  // Shift-add multiplier step: add multiplicand on lsb, shift product right
  logic [W:0]   mul_sum;
  logic [W-1:0] mul_hi_nx, mul_lo_nx;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi_nx = mul_sum[W:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo[W-1:1]};

`ifdef CPU_EXEC_DIVIDER_EN
  // Restoring divider step; a zero divisor freezes the dividend so it can be returned
  logic         is_mod;
  logic [W:0]   div_sh, div_diff;
  logic         div_ge, div_zero;
  logic [W-1:0] div_hi_nx, div_lo_nx, div_res;

  assign div_sh    = {acc_hi, acc_lo[W-1]};
  assign div_diff  = div_sh - {1'b0, opnd};
  assign div_ge    = ~div_diff[W];
  assign div_zero  = (opnd == '0);
  assign div_hi_nx = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
  assign div_lo_nx = {acc_lo[W-2:0], div_ge};
  assign div_res   = div_zero ? '1 : (is_mod ? div_hi_nx : div_lo_nx);
`endif

  // ALU FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      iter_cnt      <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      opnd          <= '0;
      busy          <= 1'b0;
      result        <= '0;
      remainder     <= '0;
      overflow_flag <= 1'b0;
      carry_flag    <= 1'b0;
      negative_flag <= 1'b0;
      zero_flag     <= 1'b0;
`ifdef CPU_EXEC_DIVIDER_EN
      is_mod        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_mul || start_div) begin
              state    <= start_mul ? S_MUL : S_DIV;
              busy     <= 1'b1;
              iter_cnt <= '0;
              acc_hi   <= '0;
              acc_lo   <= b;
              opnd     <= a;
`ifdef CPU_EXEC_DIVIDER_EN
              is_mod   <= (op_code == OP_MOD);
`endif
            end else if (sc_valid) begin
              if (sc_wr_res)  result    <= sc_val;
              if (sc_rem_clr) remainder <= '0;
              overflow_flag <= sc_v;
              carry_flag    <= sc_c;
              negative_flag <= sc_val[W-1];
              zero_flag     <= (sc_val == '0);
            end
          end
        end
        S_MUL: begin
          acc_hi   <= mul_hi_nx;
          acc_lo   <= mul_lo_nx;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (iter_cnt == '1) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            result        <= mul_lo_nx;
            overflow_flag <= 1'b0;
            carry_flag    <= |mul_hi_nx;
            negative_flag <= mul_lo_nx[W-1];
            zero_flag     <= (mul_lo_nx == '0);
          end
        end
`ifdef CPU_EXEC_DIVIDER_EN
        S_DIV: begin
          if (!div_zero) begin
            acc_hi <= div_hi_nx;
            acc_lo <= div_lo_nx;
          end
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (iter_cnt == '1) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            result        <= div_res;
            remainder     <= div_zero ? acc_lo : div_hi_nx;
            overflow_flag <= div_zero;
            carry_flag    <= 1'b0;
            negative_flag <= div_res[W-1];
            zero_flag     <= (div_res == '0);
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Program counter; a jump also captures the return address
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_out         <= '0;
      pc_out_for_mem <= '0;
    end else if (save_address_from_instr_mem) begin
      pc_out         <= address_from_instr_mem;
      pc_out_for_mem <= pc_out + W'(1);
    end else if (save_address_from_data_mem) begin
      pc_out <= address_from_data_mem;
    end else if (save_address_from_counter) begin
      pc_out <= address_from_counter_pc;
    end else if (increm_pc) begin
      pc_out <= pc_out + W'(1);
    end
  end

  // Stack pointer, saturating at both ends of the stack window
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_out <= SP_TOP;
    end else if (push && !pop && (sp_out != SP_FLOOR)) begin
      sp_out <= sp_out - W'(1);
    end else if (pop && !push && (sp_out != SP_TOP)) begin
      sp_out <= sp_out + W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Self-checking bench for cpu_exec_unit: directed plan steps plus random ALU/PC/SP traffic.
module tb_cpu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mov_enable;
  logic [5:0]  op_code;
  logic [15:0] a, b, result, remainder;
  logic        busy, overflow_flag, carry_flag, negative_flag, zero_flag;
  logic        push, pop;
  logic [15:0] sp_out;
  logic        save_address_from_instr_mem, save_address_from_data_mem;
  logic        save_address_from_counter, increm_pc;
  logic [15:0] address_from_instr_mem, address_from_data_mem, address_from_counter_pc;
  logic [15:0] pc_out, pc_out_for_mem;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic        v, c, n, z;
  } alu_st_t;

  alu_st_t     m;
  logic [15:0] m_pc, m_pcm, m_sp;

  always #5 clk = ~clk;

  cpu_exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .mov_enable(mov_enable), .op_code(op_code),
    .a(a), .b(b), .result(result), .remainder(remainder), .busy(busy),
    .overflow_flag(overflow_flag), .carry_flag(carry_flag),
    .negative_flag(negative_flag), .zero_flag(zero_flag),
    .push(push), .pop(pop), .sp_out(sp_out),
    .save_address_from_instr_mem(save_address_from_instr_mem),
    .save_address_from_data_mem(save_address_from_data_mem),
    .save_address_from_counter(save_address_from_counter), .increm_pc(increm_pc),
    .address_from_instr_mem(address_from_instr_mem),
    .address_from_data_mem(address_from_data_mem),
    .address_from_counter_pc(address_from_counter_pc),
    .pc_out(pc_out), .pc_out_for_mem(pc_out_for_mem)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " result"}, 32'(result), 32'(m.res));
    chk({tag, " remainder"}, 32'(remainder), 32'(m.rem));
    chk({tag, " flags"}, 32'({overflow_flag, carry_flag, negative_flag, zero_flag}),
        32'({m.v, m.c, m.n, m.z}));
    chk({tag, " busy"}, 32'(busy), 32'(0));
    chk({tag, " pc"}, 32'(pc_out), 32'(m_pc));
    chk({tag, " pc_mem"}, 32'(pc_out_for_mem), 32'(m_pcm));
    chk({tag, " sp"}, 32'(sp_out), 32'(m_sp));
  endtask

  function automatic logic ovf(input int s);
    return (s > 32767 || s < -32768) ? 1'b1 : 1'b0;
  endfunction

  // Architectural ALU model: integer arithmetic on the opcode rules
  function automatic alu_st_t ref_alu(input alu_st_t cur, input logic [5:0] op,
                                      input logic [15:0] av, input logic [15:0] bv,
                                      input logic men, output bit multi);
    alu_st_t     nx;
    int unsigned ua, ub, u, sh;
    int          sa, sb;
    logic [15:0] val;
    bit          wr, exec;
    nx = cur; multi = 0; wr = 1; exec = 1; val = '0;
    ua = av; ub = bv; sa = $signed(av); sb = $signed(bv); sh = av[3:0];
    nx.v = 1'b0; nx.c = 1'b0;
    case (op)
      6'h01: begin u = ub + ua; val = u[15:0]; nx.c = (u > 65535); nx.v = ovf(sb + sa); end
      6'h02, 6'h0E: begin
        val = 16'(ub - ua); nx.c = (ub < ua); nx.v = ovf(sb - sa); wr = (op == 6'h02);
      end
      6'h03: begin multi = 1; u = ub * ua; val = u[15:0]; nx.c = ((u >> 16) != 0); end
      6'h04, 6'h05: begin
`ifdef CPU_EXEC_DIVIDER_EN
        multi = 1;
        if (ua == 0) begin
          val = 16'hFFFF; nx.rem = bv; nx.v = 1'b1;
        end else begin
          nx.rem = 16'(ub % ua);
          val = (op == 6'h04) ? 16'(ub / ua) : 16'(ub % ua);
        end
`else
        val = 16'h0000; nx.rem = 16'h0000; nx.v = 1'b1;
`endif
      end
      6'h06, 6'h0F: begin val = bv & av; wr = (op == 6'h06); end
      6'h07: val = bv | av;
      6'h08: val = bv ^ av;
      6'h09: val = ~bv;
      6'h0A: begin val = 16'(ub << sh); nx.c = (sh != 0) && (((ub >> (16 - sh)) & 1) == 1); end
      6'h0B: begin val = 16'(ub >> sh); nx.c = (sh != 0) && (((ub >> (sh - 1)) & 1) == 1); end
      6'h0C: begin u = ub + 1; val = u[15:0]; nx.c = (u > 65535); nx.v = ovf(sb + 1); end
      6'h0D: begin val = 16'(ub - 1); nx.c = (ub == 0); nx.v = ovf(sb - 1); end
      6'h10: begin if (men) val = av; else exec = 0; end
      default: exec = 0;
    endcase
    if (!exec) return cur;
    nx.z = (val == 16'h0000);
    nx.n = val[15];
    if (wr) nx.res = val;
    return nx;
  endfunction

  task automatic do_alu(input string tag, input logic [5:0] op, input logic [15:0] av,
                        input logic [15:0] bv, input logic men, input bit poke);
    alu_st_t nx;
    bit      multi;
    int      n;
    nx = ref_alu(m, op, av, bv, men, multi);
    op_code = op; a = av; b = bv; mov_enable = men; start = 1'b1;
    tick();
    start = 1'b0;
    if (multi) begin
      chk({tag, " busy_on_start"}, 32'(busy), 32'(1));
      n = 1;
      if (poke) begin
        // a second start while busy must be ignored
        op_code = 6'h10; a = 16'h0077; mov_enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; n = 2;
      end
      while (busy === 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(17));
    end
    a = 16'($urandom); b = 16'($urandom); op_code = 6'($urandom);
    m = nx;
    chk_all(tag);
  endtask

  task automatic pc_step(input string tag, input logic si, input logic sd, input logic sc,
                         input logic inc, input logic [15:0] ai, input logic [15:0] ad,
                         input logic [15:0] ac);
    save_address_from_instr_mem = si; save_address_from_data_mem = sd;
    save_address_from_counter = sc; increm_pc = inc;
    address_from_instr_mem = ai; address_from_data_mem = ad; address_from_counter_pc = ac;
    tick();
    {save_address_from_instr_mem, save_address_from_data_mem,
     save_address_from_counter, increm_pc} = 4'b0000;
    if (si) begin m_pcm = 16'(int'(m_pc) + 1); m_pc = ai; end
    else if (sd) m_pc = ad;
    else if (sc) m_pc = ac;
    else if (inc) m_pc = 16'(int'(m_pc) + 1);
    chk({tag, " pc"}, 32'(pc_out), 32'(m_pc));
    chk({tag, " pc_mem"}, 32'(pc_out_for_mem), 32'(m_pcm));
  endtask

  task automatic sp_step(input string tag, input logic pu, input logic po);
    int s;
    push = pu; pop = po;
    tick();
    push = 1'b0; pop = 1'b0;
    s = m_sp;
    if (pu && !po && s > 'h100) s--;
    else if (po && !pu && s < 'h1FF) s++;
    m_sp = 16'(s);
    chk({tag, " sp"}, 32'(sp_out), 32'(m_sp));
  endtask

  task automatic model_reset();
    m = '{res: 16'h0, rem: 16'h0, v: 1'b0, c: 1'b0, n: 1'b0, z: 1'b0};
    m_pc = 16'h0; m_pcm = 16'h0; m_sp = 16'h01FF;
  endtask

  initial begin
    logic [15:0] ra;
    // Reset with push/increm_pc active must still land on reset values
    rst = 1'b0; start = 1'b0; mov_enable = 1'b0; op_code = 6'h00; a = 16'h0; b = 16'h0;
    push = 1'b1; pop = 1'b0; increm_pc = 1'b1;
    save_address_from_instr_mem = 1'b0; save_address_from_data_mem = 1'b0;
    save_address_from_counter = 1'b0;
    address_from_instr_mem = 16'h0; address_from_data_mem = 16'h0;
    address_from_counter_pc = 16'h0;
    tick();
    rst = 1'b1; push = 1'b0; increm_pc = 1'b0;
    model_reset();
    chk_all("reset");

    do_alu("add_wrap", 6'h01, 16'h0001, 16'hFFFF, 1'b0, 0);
    do_alu("sub_neg", 6'h02, 16'h0005, 16'h0003, 1'b0, 0);
    do_alu("mov_off", 6'h10, 16'h0155, 16'h1234, 1'b0, 0);
    do_alu("mov_on", 6'h10, 16'h0155, 16'h1234, 1'b1, 0);
    do_alu("undef", 6'h2A, 16'h0001, 16'h0001, 1'b1, 0);
    do_alu("add_ovf", 6'h01, 16'h0001, 16'h7FFF, 1'b0, 0);
    do_alu("cmp", 6'h0E, 16'h0010, 16'h0010, 1'b0, 0);
    do_alu("lsl", 6'h0A, 16'h0004, 16'h1801, 1'b0, 0);
    do_alu("lsr", 6'h0B, 16'h0003, 16'h0005, 1'b0, 0);
    do_alu("mul", 6'h03, 16'h0010, 16'h0123, 1'b0, 0);
    do_alu("mul_busy_start", 6'h03, 16'h01FF, 16'hABCD, 1'b0, 1);
    do_alu("div", 6'h04, 16'h0007, 16'h0064, 1'b0, 0);
    do_alu("mod", 6'h05, 16'h0007, 16'h0064, 1'b0, 0);
    do_alu("div_zero", 6'h04, 16'h0000, 16'h4321, 1'b0, 1);

    for (int i = 0; i < 60; i++) begin
      ra = (i % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 511));
      do_alu("rand_alu", 6'($urandom_range(0, 20)), ra, 16'($urandom), 1'($urandom), 0);
    end

    // PC priority and wrap
    pc_step("pc_load5", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0005);
    pc_step("pc_all3", 1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h0BAD, 16'h0BEE);
    pc_step("pc_ret", 1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0006, 16'h0BEE);
    pc_step("pc_ctr", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'hFFFF);
    pc_step("pc_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
    pc_step("pc_hold", 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333);
    for (int i = 0; i < 60; i++)
      pc_step("pc_rand", 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom));

    // Stack bounds
    for (int i = 0; i < 257; i++) sp_step("sp_push", 1'b1, 1'b0);
    sp_step("sp_both_floor", 1'b1, 1'b1);
    for (int i = 0; i < 257; i++) sp_step("sp_pop", 1'b0, 1'b1);
    sp_step("sp_both_top", 1'b1, 1'b1);
    for (int i = 0; i < 80; i++) sp_step("sp_rand", 1'($urandom), 1'($urandom));

    // Reset in the middle of a multiply, then a clean multiply
    op_code = 6'h03; a = 16'h0010; b = 16'h0123; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_mul busy", 32'(busy), 32'(1));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    chk_all("mid_mul_reset");
    do_alu("mul_after_reset", 6'h03, 16'h0010, 16'h0123, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
